// File: rtl/cmos_pkg.sv
// Shared definitions for the PCF8583-style I2C CMOS RAM: states, address, RTC indices, BCD helpers.
package cmos_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEVADDR  = 4'd1,
    ST_ACK_DEV  = 4'd2,
    ST_WORDADDR = 4'd3,
    ST_ACK_WORD = 4'd4,
    ST_WRDATA   = 4'd5,
    ST_ACK_WR   = 4'd6,
    ST_RDDATA   = 4'd7,
    ST_RDACK    = 4'd8
  } state_e;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

  localparam logic [7:0] RTC_HUND = 8'h01;
  localparam logic [7:0] RTC_SEC  = 8'h02;
  localparam logic [7:0] RTC_MIN  = 8'h03;
  localparam logic [7:0] RTC_HOUR = 8'h04;

  localparam logic [7:0] BCD_MAX_HUND = 8'h99;
  localparam logic [7:0] BCD_MAX_SEC  = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

  // Returns {carry, next}; wraps to 0x00 with carry when v equals lim.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [8:0] r;
    if (v == lim) begin
      r = {1'b1, 8'h00};
    end else if (v[3:0] == 4'h9) begin
      r = {1'b0, v[7:4] + 4'h1, 4'h0};
    end else begin
      r = {1'b0, v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

  function automatic logic [7:0] rtc_mux(input logic [7:0] addr, input logic [7:0] ram,
                                         input logic [31:0] rtc);
    logic [7:0] r;
    case (addr)
      RTC_HUND: r = rtc[7:0];
      RTC_SEC:  r = rtc[15:8];
      RTC_MIN:  r = rtc[23:16];
      RTC_HOUR: r = rtc[31:24];
      default:  r = ram;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmos_rtc_counter.sv
// BCD time-of-day cascade (hundredths, seconds, minutes, hours) advanced by a 100 Hz tick.
module cmos_rtc_counter
  import cmos_pkg::*;
(
  input  logic        clkcpu,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [7:0]  wdata_i,
  output logic [31:0] rtc_o
);

  logic [7:0] hund_q, hund_d, sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [8:0] hund_inc_s, sec_inc_s, min_inc_s, hour_inc_s;
  logic       c_sec_s, c_min_s, c_hour_s;

  // Carry chain from old values; a write to a byte overrides that byte's tick only.
  always_comb begin
    hund_inc_s = bcd_inc(hund_q, BCD_MAX_HUND);
    sec_inc_s  = bcd_inc(sec_q, BCD_MAX_SEC);
    min_inc_s  = bcd_inc(min_q, BCD_MAX_MIN);
    hour_inc_s = bcd_inc(hour_q, BCD_MAX_HOUR);
    c_sec_s    = tick_i & hund_inc_s[8];
    c_min_s    = c_sec_s & sec_inc_s[8];
    c_hour_s   = c_min_s & min_inc_s[8];
    hund_d = (we_i && (waddr_i == RTC_HUND)) ? wdata_i : (tick_i   ? hund_inc_s[7:0] : hund_q);
    sec_d  = (we_i && (waddr_i == RTC_SEC))  ? wdata_i : (c_sec_s  ? sec_inc_s[7:0]  : sec_q);
    min_d  = (we_i && (waddr_i == RTC_MIN))  ? wdata_i : (c_min_s  ? min_inc_s[7:0]  : min_q);
    hour_d = (we_i && (waddr_i == RTC_HOUR)) ? wdata_i : (c_hour_s ? hour_inc_s[7:0] : hour_q);
  end

  always_ff @(posedge clkcpu or posedge rst_i) begin
    if (rst_i) begin
      hund_q <= 8'h00;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hour_q <= 8'h00;
    end else begin
      hund_q <= hund_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign rtc_o = {hour_q, min_q, sec_q, hund_q};

endmodule

// File: rtl/i2c_cmos.sv
// I2C responder modelling PCF8583 CMOS RAM with a host side port.
// Optional BCD clock at bytes 0x01-0x04 when CMOS_RTC_EN is defined.
module i2c_cmos
  import cmos_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic       clkcpu,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic [7:0] host_addr,
  input  logic       host_we,
  input  logic [7:0] host_din,
  output logic [7:0] host_dout,
  input  logic       cs_tick
);

  logic [7:0] mem [0:255];

  logic       scl_s1_q, scl_s2_q, scl_h_q, sda_s1_q, sda_s2_q, sda_h_q;
  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d, host_dout_q, host_dout_d;
  logic       sda_o_q, sda_o_d, rw_q, rw_d;
  logic       scl_rise_s, scl_fall_s, start_s, stop_s, i2c_we_s, wr_en_s;
  logic [7:0] rx_byte_s, rd_addr_s, rd_byte_s, host_rd_s, wr_addr_s, wr_data_s;

  // Synchronizers reset to the idle-bus level so reset itself never looks like START.
  always_ff @(posedge clkcpu or posedge rst_i) begin
    if (rst_i) begin
      {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
      {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
    end else begin
      {scl_s1_q, scl_s2_q, scl_h_q} <= {scl_i, scl_s1_q, scl_s2_q};
      {sda_s1_q, sda_s2_q, sda_h_q} <= {sda_i, sda_s1_q, sda_s2_q};
    end
  end

  assign scl_rise_s = scl_s2_q & ~scl_h_q;
  assign scl_fall_s = ~scl_s2_q & scl_h_q;
  assign start_s    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_s     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign rx_byte_s  = {shift_q[6:0], sda_s2_q};
  assign rd_addr_s  = (state_q == ST_RDACK) ? (ptr_q + 8'd1) : ptr_q;

  // Read muxing: RTC flops shadow RAM bytes 0x01-0x04 when the clock is built in.
`ifdef CMOS_RTC_EN
  logic [31:0] rtc_s;

  cmos_rtc_counter u_rtc (
    .clkcpu  (clkcpu),
    .rst_i   (rst_i),
    .tick_i  (cs_tick),
    .we_i    (wr_en_s),
    .waddr_i (wr_addr_s),
    .wdata_i (wr_data_s),
    .rtc_o   (rtc_s)
  );

  assign rd_byte_s = rtc_mux(rd_addr_s, mem[rd_addr_s], rtc_s);
  assign host_rd_s = rtc_mux(host_addr, mem[host_addr], rtc_s);
`else
  logic unused_tick_s;

  assign unused_tick_s = cs_tick;
  assign rd_byte_s     = mem[rd_addr_s];
  assign host_rd_s     = mem[host_addr];
`endif

  // Single write port; a host write in the same cycle wins and the I2C byte is dropped.
  always_comb begin
    wr_en_s = host_we | i2c_we_s;
    if (host_we) begin
      wr_addr_s = host_addr;
      wr_data_s = host_din;
    end else begin
      wr_addr_s = ptr_q;
      wr_data_s = rx_byte_s;
    end
  end

  always_ff @(posedge clkcpu) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= wr_data_s;
    end
  end

  // Protocol FSM: sample on scl rise, change sda_o only on scl fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_o_d     = sda_o_q;
    rw_d        = rw_q;
    i2c_we_s    = 1'b0;
    host_dout_d = host_rd_s;
    if (start_s) begin
      state_d   = ST_DEVADDR;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
    end else if (scl_rise_s) begin
      case (state_q)
        ST_DEVADDR, ST_WORDADDR, ST_WRDATA: begin
          shift_d   = rx_byte_s;
          bit_cnt_d = 4'd8;
          if (bit_cnt_q != 4'd7) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (state_q == ST_DEVADDR) begin
            if (rx_byte_s[7:1] == DEV_ADDR) begin
              state_d = ST_ACK_DEV;
              rw_d    = rx_byte_s[0];
            end else begin
              state_d   = ST_IDLE;
              bit_cnt_d = 4'd0;
            end
          end else if (state_q == ST_WORDADDR) begin
            ptr_d   = rx_byte_s;
            state_d = ST_ACK_WORD;
          end else begin
            i2c_we_s = 1'b1;
            state_d  = ST_ACK_WR;
          end
        end
        ST_ACK_DEV, ST_ACK_WORD, ST_ACK_WR: bit_cnt_d = 4'd9;
        ST_RDDATA: bit_cnt_d = bit_cnt_q + 4'd1;
        ST_RDACK: begin
          if (!sda_s2_q) begin
            ptr_d     = ptr_q + 8'd1;
            shift_d   = rd_byte_s;
            bit_cnt_d = 4'd0;
            state_d   = ST_RDDATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (scl_fall_s) begin
      case (state_q)
        ST_ACK_DEV, ST_ACK_WORD, ST_ACK_WR: begin
          if (bit_cnt_q == 4'd8) begin
            sda_o_d = 1'b0;
          end else begin
            sda_o_d   = 1'b1;
            bit_cnt_d = 4'd0;
            if (state_q == ST_ACK_WR) begin
              state_d = ST_WRDATA;
              ptr_d   = ptr_q + 8'd1;
            end else if (state_q == ST_ACK_WORD) begin
              state_d = ST_WRDATA;
            end else if (rw_q) begin
              // First read bit goes out on the same fall that ends the address ACK.
              state_d = ST_RDDATA;
              sda_o_d = rd_byte_s[7];
              shift_d = {rd_byte_s[6:0], 1'b0};
            end else begin
              state_d = ST_WORDADDR;
            end
          end
        end
        ST_RDDATA: begin
          if (bit_cnt_q == 4'd8) begin
            sda_o_d = 1'b1;
            state_d = ST_RDACK;
          end else begin
            sda_o_d = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        default: sda_o_d = sda_o_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Protocol and side-port registers.
  always_ff @(posedge clkcpu or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      sda_o_q     <= 1'b1;
      rw_q        <= 1'b0;
      host_dout_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_o_q     <= sda_o_d;
      rw_q        <= rw_d;
      host_dout_q <= host_dout_d;
    end
  end

  assign sda_o     = sda_o_q;
  assign host_dout = host_dout_q;

endmodule

// File: doc/i2c_cmos.md
# i2c_cmos

Models the PCF8583 CMOS RAM/clock chip as an I2C responder on the two-wire bus bit-banged by IOC control lines C0/C1. Provides 256 bytes of battery-backed configuration RAM that RISC OS reads and writes over I2C. A side port lets the platform preload and save the contents. It sits in the Archimedes top level, beside IOC, on the I2C_CLOCK/I2C_DOUT/I2C_DIN nets.

## Interface
Parameters:
- DEV_ADDR, 7'h50, 7-bit slave address; 8-bit form is 0xA0 for write, 0xA1 for read.

Ports (one clock; reset is asynchronous and active-high):
- clkcpu  in  1  system CPU clock; all logic is on its rising edge.
- rst_i  in  1  asynchronous active-high reset.
- scl_i  in  1  I2C clock from the host (I2C_CLOCK).
- sda_i  in  1  I2C data from the host (I2C_DOUT).
- sda_o  out  1  open-drain data: 0 pulls low, 1 releases. Wired-AND with sda_i externally to form I2C_DIN.
- host_addr  in  8  side-port byte address.
- host_we  in  1  side-port write strobe, one cycle.
- host_din  in  8  side-port write data.
- host_dout  out  8  side-port read data, registered.
- cs_tick  in  1  100 Hz single-cycle pulse. Used only when CMOS_RTC_EN is defined.

## Operation
- scl_i and sda_i each pass through a 2-flop synchronizer plus a history flop.
- Edge detection works on the synchronized values:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - rise/fall: scl edges.
- The bit counter takes the sampled data on the scl rising edge. sda_o changes only on the scl falling edge.
- States: IDLE, DEVADDR, ACK_DEV, WORDADDR, ACK_WORD, WRDATA, ACK_WR, RDDATA, RDACK.
- IDLE → DEVADDR on START.
- DEVADDR shifts in 8 bits, MSB first.
  - If [7:1] == DEV_ADDR: go to ACK_DEV and drive sda_o=0 for the 9th clock.
  - Otherwise: return to IDLE with the bus released.
- ACK_DEV exits on the 9th scl falling edge:
  - R/W=0 → WORDADDR.
  - R/W=1 → RDDATA, with the shift register loaded from mem[ptr].
- WORDADDR shifts in 8 bits, sets ptr, then goes to ACK_WORD (ack driven) → WRDATA.
- WRDATA shifts in 8 bits and writes mem[ptr] on the 8th scl rise. It then goes to ACK_WR (ack driven) → WRDATA with ptr+1.
- RDDATA drives the shift-register MSB on each scl fall. After 8 bits it releases sda and goes to RDACK. The master's bit is sampled on the 9th rise:
  - 0 (ACK): ptr+1, reload from mem[ptr+1], back to RDDATA.
  - 1 (NACK): IDLE.
- ptr is 8 bits and wraps from 0xFF to 0x00 on both read and write.
- START in any state (repeated start) → DEVADDR with the bit counter cleared. ptr is kept.
- STOP in any state → IDLE with sda_o=1. ptr is kept.
- Side port: host_dout <= mem[host_addr] every cycle.
  - When host_we is high, mem[host_addr] <= host_din.
  - If the side port and I2C write the same cycle, the side-port write takes effect and the I2C write is dropped.
- mem is an inferred 256x8 RAM and is not cleared by reset.

## Timing
- Reset values:
  - sda_o=1.
  - host_dout=0.
  - state IDLE, ptr=0, bit counter 0.
  - synchronizer flops set to 1 (idle bus).
- Pin-to-internal-edge latency is 3 clkcpu cycles. sda_o updates 1 cycle after the detected scl fall, i.e. 4 cycles after the pin.
- The host must hold SDA stable for at least 4 clkcpu cycles around each scl edge. IOC bit-banging meets this by orders of magnitude.
- A read-data byte is fetched from RAM in the cycle of the ACK decision. It is valid before the next scl fall.
- host_dout has 1-cycle read latency.
- If rst_i is asserted mid-transfer, sda_o is released immediately (asynchronously). The bus recovers on the next START.

## Configuration
- Macro: CMOS_RTC_EN.
- Defined:
  - Bytes 0x01–0x04 form a BCD counter: hundredths, seconds, minutes, hours (24 h).
  - Each cs_tick advances it with carries 99→00, 59→00, 23→00.
  - An I2C write to one of these bytes in the same cycle as a tick has priority; the tick is lost for that byte only.
- Undefined: bytes 0x01–0x04 are plain RAM and cs_tick is ignored.

## Structure
- Shared package cmos_pkg holds:
  - state encoding localparams;
  - the default DEV_ADDR;
  - RTC register indices (0x01–0x04);
  - BCD limits.
- One sub-module, cmos_rtc_counter: the BCD cascade, instantiated only under CMOS_RTC_EN.
- The RTC registers live in flops inside cmos_rtc_counter. They are muxed over the RAM for reads.

## Test plan
- Write then read back:
  - Write 0xA0, 0x10, 0x5A, 0xC3, STOP → mem[0x10]=0x5A and mem[0x11]=0xC3, with an ACK on all 4 bytes.
  - Then START, 0xA0, 0x10, repeated START, 0xA1, read 2 bytes (ACK, then NACK) → 0x5A, 0xC3.
- Address mismatch: send 0xA2 → sda_o stays 1 through the 9th clock, state returns to IDLE, and no write occurs.
- Pointer wrap: word address 0xFF, then write 0x11 and 0x22 → mem[0xFF]=0x11 and mem[0x00]=0x22.
- Side-port collision: host_we to 0x20 with 0x77 in the same cycle as an I2C write of 0x20=0x55 → mem[0x20]=0x77. host_dout shows 0x77 one cycle after host_addr=0x20.
- Reset mid-read: assert rst_i while sda_o=0 during RDDATA → sda_o=1 immediately. The next transaction (0xA1, read) returns mem[ptr], where ptr=0 because reset cleared it.
- RTC (CMOS_RTC_EN): preload 0x01..0x04 = 0x99, 0x59, 0x59, 0x23, then one cs_tick → all four read back 0x00.
